uart_rx_frame_engine: RTL and testbench

Parametrised UART receive framing engine, the successor to the fixed 8-bit serial-to-parallel deserializer. It consumes mid-bit samples from the RX sampler and tracks start, data, optional parity and 1 or 2 stop bits with its own bit counter. It assembles a DATA_WIDTH word and presents it through a one-entry holding register with a valid/ready handshake toward the APB register file. It reports parity, framing and overrun errors; break detection is an optional compile-time feature.

---
 rtl/uart_rx_frame_engine_if.sv | 29 ++
 rtl/uart_rx_frame_engine.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_frame_engine.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_engine_if.sv
// Bundle between the UART RX framing engine and its sampler/consumer.
// master = framing engine, slave = sampler + APB register file side.
interface uart_rx_frame_engine_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  sample_strobe;
    logic                  sampled_bit;
    logic                  parity_en;
    logic                  parity_odd;
    logic                  two_stop;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  break_det;
    logic                  overrun_err;
    logic                  busy;

    modport master (
        input  sample_strobe, sampled_bit, parity_en, parity_odd, two_stop, rx_ready,
        output rx_data, rx_valid, parity_err, frame_err, break_det, overrun_err, busy
    );

    modport slave (
        output sample_strobe, sampled_bit, parity_en, parity_odd, two_stop, rx_ready,
        input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun_err, busy
    );
endinterface

// File: rtl/uart_rx_frame_engine.sv
// UART receive framing engine: start/data/parity/stop tracking into a one-entry holding register.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_frame_engine #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic                    UCLK,
    input logic                    reset,
    uart_rx_frame_engine_if.master bus
);
    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {StIdle, StData, StParity, StStop1, StStop2} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_pend_q, par_pend_d;
    logic                  frm_pend_q, frm_pend_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  start;
    logic                  complete;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                  zero_q, zero_d;     // every bit so far sampled 0
    logic                  brk_q, brk_d;
    logic                  brk_wait_q, brk_wait_d;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_pend_d = par_pend_q;
        frm_pend_d = frm_pend_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = 1'b0;
        start      = 1'b0;
        complete   = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        zero_d     = zero_q;
        brk_d      = brk_q;
        brk_wait_d = brk_wait_q;
        // After a break, the line must return to mark before a new start bit counts.
        if (state_q == StIdle && bus.sample_strobe) begin
            if (brk_wait_q) begin
                brk_wait_d = ~bus.sampled_bit;
            end else begin
                start = ~bus.sampled_bit;
            end
        end
`else
        start = (state_q == StIdle) && bus.sample_strobe && !bus.sampled_bit;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StData;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    par_pend_d = 1'b0;
                    frm_pend_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d     = 1'b1;
`endif
                end
            end
            StData: begin
                if (bus.sample_strobe) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (bit_cnt_q == CntW'(i)) shift_d[i] = bus.sampled_bit;
                    end
                    bit_cnt_d = bit_cnt_q + CntW'(1);
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d = zero_q & ~bus.sampled_bit;
`endif
                    if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        state_d = bus.parity_en ? StParity : StStop1;
                    end
                end
            end
            StParity: begin
                if (bus.sample_strobe) begin
                    if (bus.sampled_bit != (^shift_q ^ bus.parity_odd)) par_pend_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d = zero_q & ~bus.sampled_bit;
`endif
                    state_d = StStop1;
                end
            end
            StStop1: begin
                if (bus.sample_strobe) begin
                    if (!bus.sampled_bit) frm_pend_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d = zero_q & ~bus.sampled_bit;
`endif
                    if (bus.two_stop) begin
                        state_d = StStop2;
                    end else begin
                        state_d  = StIdle;
                        complete = 1'b1;
                    end
                end
            end
            StStop2: begin
                if (bus.sample_strobe) begin
                    if (!bus.sampled_bit) frm_pend_d = 1'b1;
                    state_d  = StIdle;
                    complete = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A completion may reuse the slot being emptied in the same cycle.
        if (complete) begin
            if (!valid_q || bus.rx_ready) begin
                data_d  = shift_q;
                perr_d  = par_pend_d;
                ferr_d  = frm_pend_d;
                valid_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                brk_d   = zero_d;
`endif
            end else begin
                ovr_d = 1'b1;
            end
`ifdef UART_RX_BREAK_DETECT_EN
            brk_wait_d = zero_d;
`endif
        end else if (valid_q && bus.rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_pend_q <= 1'b0;
            frm_pend_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q     <= 1'b0;
            brk_q      <= 1'b0;
            brk_wait_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_pend_q <= par_pend_d;
            frm_pend_q <= frm_pend_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q     <= zero_d;
            brk_q      <= brk_d;
            brk_wait_q <= brk_wait_d;
`endif
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.rx_valid    = valid_q;
    assign bus.parity_err  = perr_q;
    assign bus.frame_err   = ferr_q;
    assign bus.overrun_err = ovr_q;
    assign bus.busy        = (state_q != StIdle);
`ifdef UART_RX_BREAK_DETECT_EN
    assign bus.break_det   = brk_q;
`else
    assign bus.break_det   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// Scoreboard bench for uart_rx_frame_engine: directed frames push expected words,
// a negedge monitor pops and compares on every accepted handshake.
module tb_uart_rx_frame_engine;
    localparam int unsigned DW = 8;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam logic BrkEn = 1'b1;
`else
    localparam logic BrkEn = 1'b0;
`endif

    logic UCLK = 1'b0;
    logic reset;

    uart_rx_frame_engine_if #(.DATA_WIDTH(DW)) rx_if ();

    uart_rx_frame_engine #(.DATA_WIDTH(DW)) dut (
        .UCLK  (UCLK),
        .reset (reset),
        .bus   (rx_if)
    );

    always #5 UCLK = ~UCLK;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
        logic          brk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total    = 0;
    int   bad      = 0;
    int   ovr_seen = 0;
    int   ovr_exp  = 0;
    logic last_busy, last_valid, stop_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic p, input logic f, input logic b);
        exp_q.push_back({d, p, f, b});
    endtask

    // Monitor: every accepted word must match the oldest expectation.
    always @(negedge UCLK) begin
        if (rx_if.overrun_err === 1'b1) ovr_seen++;
        if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected word: got %0h expected none", rx_if.rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_data", rx_if.rx_data, mon_e.data);
                check("parity_err", rx_if.parity_err, mon_e.perr);
                check("frame_err", rx_if.frame_err, mon_e.ferr);
                check("break_det", rx_if.break_det, mon_e.brk);
            end
        end
    end

    task automatic next_cycle();
        @(posedge UCLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_if.sample_strobe = 1'b1;
        rx_if.sampled_bit   = b;
        @(negedge UCLK);
        last_busy  = rx_if.busy;
        last_valid = rx_if.rx_valid;
        next_cycle();
        rx_if.sample_strobe = 1'b0;
        rx_if.sampled_bit   = 1'b1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic s1,
                              input logic s2, input logic ready_last);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        if (rx_if.parity_en) send_bit(pbit);
        if (rx_if.two_stop) begin
            send_bit(s1);
            stop_busy = last_busy;
            if (ready_last) rx_if.rx_ready = 1'b1;
            send_bit(s2);
            stop_busy = stop_busy & last_busy;
        end else begin
            if (ready_last) rx_if.rx_ready = 1'b1;
            send_bit(s1);
            stop_busy = last_busy;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        rx_if.sample_strobe = 1'b0;
        rx_if.sampled_bit   = 1'b1;
        rx_if.parity_en     = 1'b0;
        rx_if.parity_odd    = 1'b0;
        rx_if.two_stop      = 1'b0;
        rx_if.rx_ready      = 1'b1;
        repeat (2) next_cycle();
        check("reset rx_data", rx_if.rx_data, 0);
        check("reset rx_valid", rx_if.rx_valid, 0);
        check("reset parity_err", rx_if.parity_err, 0);
        check("reset frame_err", rx_if.frame_err, 0);
        check("reset break_det", rx_if.break_det, 0);
        check("reset overrun_err", rx_if.overrun_err, 0);
        check("reset busy", rx_if.busy, 0);
        reset = 1'b0;
        next_cycle();

        // Basic 8N1 frame and latency.
        push(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t1 valid during stop strobe", last_valid, 0);
        check("t1 busy during stop strobe", stop_busy, 1);
        @(negedge UCLK);
        check("t1 valid after stop", rx_if.rx_valid, 1);
        check("t1 busy after stop", rx_if.busy, 0);
        next_cycle();
        @(negedge UCLK);
        check("t1 valid one cycle", rx_if.rx_valid, 0);
        next_cycle();

        // Even parity, back-to-back frames.
        rx_if.parity_en = 1'b1;
        push(8'h03, 1'b1, 1'b0, 1'b0);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
        push(8'h03, 1'b0, 1'b0, 1'b0);
        send_frame(8'h03, 1'b0, 1'b1, 1'b1, 1'b0);
        rx_if.parity_en = 1'b0;
        repeat (2) next_cycle();

        // Two stop bits with STOP2 sampled low.
        rx_if.two_stop = 1'b1;
        push(8'hA5, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3 busy across both stops", stop_busy, 1);
        rx_if.two_stop = 1'b0;
        repeat (2) next_cycle();

        // Overrun: second frame dropped while the first is held.
        rx_if.rx_ready = 1'b0;
        push(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
        ovr_exp++;
        @(negedge UCLK);
        check("t4 held valid", rx_if.rx_valid, 1);
        check("t4 held data", rx_if.rx_data, 8'h11);
        next_cycle();
        // Consumer drains on the completion cycle: no overrun, 0x22 loaded.
        push(8'h22, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge UCLK);
        check("t4 reload valid", rx_if.rx_valid, 1);
        check("t4 reload data", rx_if.rx_data, 8'h22);
        repeat (2) next_cycle();

        // Reset mid-frame.
        repeat (5) send_bit(1'b0);
        reset = 1'b1;
        @(negedge UCLK);
        check("t5 busy in reset", rx_if.busy, 0);
        check("t5 valid in reset", rx_if.rx_valid, 0);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        push(8'h7E, 1'b0, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) next_cycle();

        // Break frame: all zeros including STOP1.
        push('0, 1'b0, 1'b1, BrkEn);
        send_frame('0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0);
        @(negedge UCLK);
        check("t6 zero strobe after break", rx_if.busy, BrkEn ? 0 : 1);
`ifdef UART_RX_BREAK_DETECT_EN
        next_cycle();
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge UCLK);
        check("t6 start after mark", rx_if.busy, 1);
`endif
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;

        repeat (5) next_cycle();
        check("scoreboard drained", exp_q.size(), 0);
        check("overrun pulse cycles", ovr_seen, ovr_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
